wb_pbtn_debounce: RTL and testbench

WB_PBTN_DEBOUNCE -- requirements
Module: wb_pbtn_debounce

---
 rtl/wb_pbtn_pkg.sv | 17 +
 rtl/pbtn_debounce_cell.sv | 56 +++++
 rtl/wb_pbtn_debounce.sv | 124 ++++++++++++
 tb/tb_wb_pbtn_debounce.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pbtn_pkg.sv
// Shared definitions for the Wishbone push-button debouncer.
// Holds register word indices and the debounce counter width helper.
package wb_pbtn_pkg;

    typedef enum logic [2:0] {
        REG_STATE      = 3'd0,
        REG_RAW        = 3'd1,
        REG_IRQ_EN     = 3'd2,
        REG_IRQ_STATUS = 3'd3
    } reg_idx_e;

    // Bits needed to count 0 .. cycles-1.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/pbtn_debounce_cell.sv
// One push-button: 2-flop synchronizer, stability counter, stable bit.
// Ports: clk_i, rst_ni (sync, active-low), btn_i (async level),
//        raw_o (synchronized level), stable_o (debounced level),
//        rise_o (pulse in the cycle stable_o is about to go 0->1).
module pbtn_debounce_cell
    import wb_pbtn_pkg::*;
#(
    parameter int DB_CYCLES = 100000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic raw_o,
    output logic stable_o,
    output logic rise_o
);

    localparam int unsigned CW = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stable_q, stable_d;

    assign raw_o    = sync_q[1];
    assign stable_o = stable_q;

    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        rise_o   = 1'b0;
        if (raw_o == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            // Differed for DB_CYCLES consecutive cycles: accept it.
            stable_d = raw_o;
            cnt_d    = '0;
            rise_o   = raw_o;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], btn_i};
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

endmodule

// File: rtl/wb_pbtn_debounce.sv
// Wishbone slave exposing NUM_BTN debounced push-buttons and an IRQ.
// Ports: wb_clk_i, wb_rst_i (sync, active-low), Wishbone request
//        wb_adr_i/dat_i/sel_i/we_i/cyc_i/stb_i/cti_i/bte_i, response
//        wb_dat_o/ack_o/err_o/rty_o, btn_i (raw buttons), irq_o.
// Macro PBTN_IRQ_EN builds the IRQ_EN/IRQ_STATUS registers and irq_o;
// without it those registers read 0 and irq_o is tied low.
module wb_pbtn_debounce
    import wb_pbtn_pkg::*;
#(
    parameter int NUM_BTN   = 5,
    parameter int DB_CYCLES = 100000
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic [5:0]         wb_adr_i,
    input  logic [31:0]        wb_dat_i,
    input  logic [3:0]         wb_sel_i,
    input  logic               wb_we_i,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    input  logic [2:0]         wb_cti_i,
    input  logic [1:0]         wb_bte_i,
    output logic [31:0]        wb_dat_o,
    output logic               wb_ack_o,
    output logic               wb_err_o,
    output logic               wb_rty_o,
    input  logic [NUM_BTN-1:0] btn_i,
    output logic               irq_o
);

    logic [NUM_BTN-1:0] raw, stable, rise;
    logic [NUM_BTN-1:0] en_rd, sts_rd, rd_v;
    logic [2:0]         idx;
    logic               req, wr;
    logic               ack_q, ack_d;
    logic [31:0]        dat_q, dat_d;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_cell
        pbtn_debounce_cell #(
            .DB_CYCLES(DB_CYCLES)
        ) u_cell (
            .clk_i   (wb_clk_i),
            .rst_ni  (wb_rst_i),
            .btn_i   (btn_i[g]),
            .raw_o   (raw[g]),
            .stable_o(stable[g]),
            .rise_o  (rise[g])
        );
    end

    assign idx = wb_adr_i[4:2];
    assign req = wb_cyc_i & wb_stb_i & ~ack_q;
    // Write lands on the edge closing the ack cycle, once per access.
    assign wr  = ack_q & wb_cyc_i & wb_stb_i & wb_we_i & wb_sel_i[0];

`ifdef PBTN_IRQ_EN
    logic [NUM_BTN-1:0] en_q, en_d, sts_q, sts_d;

    always_comb begin
        en_d  = en_q;
        sts_d = sts_q | rise;
        if (wr && idx == REG_IRQ_EN) begin
            en_d = wb_dat_i[NUM_BTN-1:0];
        end
        if (wr && idx == REG_IRQ_STATUS) begin
            // A fresh edge wins over a simultaneous clear.
            sts_d = (sts_q & ~wb_dat_i[NUM_BTN-1:0]) | rise;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            en_q  <= '0;
            sts_q <= '0;
        end else begin
            en_q  <= en_d;
            sts_q <= sts_d;
        end
    end

    assign en_rd  = en_q;
    assign sts_rd = sts_q;
    assign irq_o  = |(sts_q & en_q);
`else
    assign en_rd  = '0;
    assign sts_rd = '0;
    assign irq_o  = 1'b0;
`endif

    always_comb begin
        rd_v = '0;
        unique case (idx)
            REG_STATE:      rd_v = stable;
            REG_RAW:        rd_v = raw;
            REG_IRQ_EN:     rd_v = en_rd;
            REG_IRQ_STATUS: rd_v = sts_rd;
            default:        rd_v = '0;
        endcase
    end

    assign ack_d = req;
    assign dat_d = req ? 32'(rd_v) : 32'h0;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= ack_d;
            dat_q <= dat_d;
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
    assign wb_err_o = 1'b0;
    assign wb_rty_o = 1'b0;

    // Bus bits with no function here (bursts run as classic cycles).
    logic unused_ok;
    assign unused_ok = ^{wb_dat_i, wb_sel_i, wb_cti_i, wb_bte_i,
                         wb_adr_i[5], wb_adr_i[1:0], wb_we_i, rise};

endmodule

// File: tb/tb_wb_pbtn_debounce.sv
// Self-checking bench for wb_pbtn_debounce (NUM_BTN=5, DB_CYCLES=4).
// Register table vectors plus directed timing sequences.
module tb_wb_pbtn_debounce;

`ifdef PBTN_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif

    localparam logic [2:0] I_STATE = 3'd0;
    localparam logic [2:0] I_RAW   = 3'd1;
    localparam logic [2:0] I_EN    = 3'd2;
    localparam logic [2:0] I_STS   = 3'd3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  adr = '0;
    logic [31:0] dat_i = '0;
    logic [3:0]  sel = '0;
    logic        we = 1'b0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic [2:0]  cti = '0;
    logic [1:0]  bte = '0;
    logic [31:0] dat_o;
    logic        ack, err, rty;
    logic [4:0]  btn = '0;
    logic        irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_pbtn_debounce #(
        .NUM_BTN  (5),
        .DB_CYCLES(4)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst_n),
        .wb_adr_i(adr),
        .wb_dat_i(dat_i),
        .wb_sel_i(sel),
        .wb_we_i (we),
        .wb_cyc_i(cyc),
        .wb_stb_i(stb),
        .wb_cti_i(cti),
        .wb_bte_i(bte),
        .wb_dat_o(dat_o),
        .wb_ack_o(ack),
        .wb_err_o(err),
        .wb_rty_o(rty),
        .btn_i   (btn),
        .irq_o   (irq)
    );

    typedef struct {
        logic [2:0]  idx;
        logic        w;
        logic [3:0]  s;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[13];

    function automatic logic [31:0] ie(input logic [31:0] v);
        return IRQ ? v : 32'h0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus(input logic [2:0] idx, input logic w,
                       input logic [3:0] s, input logic [31:0] wd,
                       output logic [31:0] rd);
        int k;
        adr   = {1'b0, idx, 2'b00};
        we    = w;
        sel   = s;
        dat_i = wd;
        cyc   = 1'b1;
        stb   = 1'b1;
        rd    = '0;
        k     = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!ack && k < 8);
        if (!ack) begin
            chk("ack_timeout", 32'(ack), 32'd1);
        end else begin
            rd = dat_o;
            chk("ack_latency", k, 1);
            chk("err", 32'(err), 32'd0);
            chk("rty", 32'(rty), 32'd0);
        end
        @(posedge clk);
        #1;
        chk("ack_width", 32'(ack), 32'd0);
        chk("dat_idle", dat_o, 32'd0);
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic [2:0] idx,
                          input logic [31:0] exp);
        logic [31:0] d;
        bus(idx, 1'b0, 4'hF, 32'h0, d);
        chk(nm, d, exp);
    endtask

    task automatic wr(input logic [2:0] idx, input logic [3:0] s,
                      input logic [31:0] wd);
        logic [31:0] d;
        bus(idx, 1'b1, s, wd, d);
    endtask

    initial begin
        logic [31:0] d;

        tbl[0]  = '{I_STATE, 1'b0, 4'hF, 32'h0,        32'h0};
        tbl[1]  = '{I_RAW,   1'b0, 4'hF, 32'h0,        32'h0};
        tbl[2]  = '{I_EN,    1'b0, 4'hF, 32'h0,        32'h0};
        tbl[3]  = '{I_EN,    1'b1, 4'hE, 32'hFF,       32'h0};
        tbl[4]  = '{I_EN,    1'b0, 4'hF, 32'h0,        32'h0};
        tbl[5]  = '{I_EN,    1'b1, 4'h1, 32'hFFFF_FFFF, 32'h0};
        tbl[6]  = '{I_EN,    1'b0, 4'hF, 32'h0,        ie(32'h1F)};
        tbl[7]  = '{3'd5,    1'b0, 4'hF, 32'h0,        32'h0};
        tbl[8]  = '{3'd7,    1'b1, 4'hF, 32'hFF,       32'h0};
        tbl[9]  = '{3'd7,    1'b0, 4'hF, 32'h0,        32'h0};
        tbl[10] = '{I_STS,   1'b0, 4'hF, 32'h0,        32'h0};
        tbl[11] = '{I_EN,    1'b1, 4'h1, 32'h0,        32'h0};
        tbl[12] = '{I_EN,    1'b0, 4'hF, 32'h0,        32'h0};

        step(3);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_dat", dat_o, 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        step(1);

        for (int i = 0; i < 13; i++) begin
            bus(tbl[i].idx, tbl[i].w, tbl[i].s, tbl[i].wd, d);
            if (!tbl[i].w) chk($sformatf("vec%0d", i), d, tbl[i].exp);
        end

        // btn2 trails btn0 by one cycle, pinning both timing edges.
        btn[0] = 1'b1;
        step(1);
        btn[2] = 1'b1;
        step(1);
        rd_chk("raw_after2", I_RAW, 32'h01);
        step(2);
        rd_chk("state_after6", I_STATE, 32'h01);
        rd_chk("state_both", I_STATE, 32'h05);
        rd_chk("sts_both", I_STS, ie(32'h05));
        btn = '0;
        step(10);
        rd_chk("state_release", I_STATE, 32'h00);
        wr(I_STS, 4'h1, 32'h1F);
        rd_chk("sts_cleared", I_STS, 32'h00);

        btn[1] = 1'b1;
        step(3);
        btn[1] = 1'b0;
        step(10);
        rd_chk("short_state", I_STATE, 32'h00);
        rd_chk("short_sts", I_STS, 32'h00);

        btn[3] = 1'b1;
        step(4);
        btn[3] = 1'b0;
        step(10);
        rd_chk("min_pulse_sts", I_STS, ie(32'h08));
        rd_chk("min_pulse_state", I_STATE, 32'h00);
        wr(I_STS, 4'h1, 32'h08);

        wr(I_EN, 4'h1, 32'h03);
        chk("irq_idle", 32'(irq), 32'd0);
        btn[1] = 1'b1;
        step(8);
        chk("irq_set", 32'(irq), ie(32'd1));
        wr(I_STS, 4'h1, 32'h02);
        chk("irq_clr", 32'(irq), 32'd0);
        rd_chk("sts_w1c", I_STS, 32'h00);
        btn[1] = 1'b0;
        step(10);

        // Write lands on the same edge as btn0's accepted rise.
        btn[0] = 1'b1;
        step(4);
        wr(I_STS, 4'h1, 32'h01);
        rd_chk("sts_coincide", I_STS, ie(32'h01));
        chk("irq_coincide", 32'(irq), ie(32'd1));
        wr(I_STS, 4'h1, 32'h01);
        rd_chk("sts_w1c0", I_STS, 32'h00);

        btn[1] = 1'b1;
        step(8);
        chk("irq_pre_rst", 32'(irq), ie(32'd1));
        adr   = {1'b0, I_STATE, 2'b00};
        we    = 1'b0;
        cyc   = 1'b1;
        stb   = 1'b1;
        rst_n = 1'b0;
        step(1);
        chk("rst_mid_ack", 32'(ack), 32'd0);
        chk("rst_mid_dat", dat_o, 32'd0);
        chk("rst_mid_irq", 32'(irq), 32'd0);
        step(1);
        cyc   = 1'b0;
        stb   = 1'b0;
        rst_n = 1'b1;
        rd_chk("post_rst_state", I_STATE, 32'h00);
        rd_chk("post_rst_en", I_EN, 32'h00);
        rd_chk("post_rst_sts", I_STS, 32'h00);
        chk("post_rst_irq", 32'(irq), 32'd0);
        step(4);
        rd_chk("held_state", I_STATE, 32'h03);
        rd_chk("held_sts", I_STS, ie(32'h03));
        chk("held_irq", 32'(irq), 32'd0);
        btn = '0;

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
